// File: rtl/predictor_saltos.sv
// Branch target buffer with 2-bit saturating counters.
// Direct-mapped, ENTRADAS entries, indexed by pc[IDX+1:2].
// Lookup is combinational for the fetch stage.
// Updates come from the execute stage on the rising clock edge.
module predictor_saltos #(
  parameter int ENTRADAS = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pcf_i,
  input  logic        actualiza_i,
  input  logic [31:0] pce_i,
  input  logic        tomado_i,
  input  logic [31:0] destinoe_i,
  output logic        hitF_o,
  output logic [1:0]  prediccionF_o,
  output logic        selbpF_o,
  output logic [31:0] destinoF_o
);

  localparam int IDX   = $clog2(ENTRADAS);
  localparam int TAG_W = 30 - IDX;

  // Valid bits and counters are reset; tags and targets are plain storage.
  logic [ENTRADAS-1:0]        valid;
  logic [ENTRADAS-1:0][1:0]   contador;
  logic [TAG_W-1:0]           etiqueta [ENTRADAS];
  logic [31:0]                destino  [ENTRADAS];

  logic [IDX-1:0]   idx_f;
  logic [IDX-1:0]   idx_e;
  logic [TAG_W-1:0] tag_f;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic             unused_bits;

  // Saturating increment towards strong-taken.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  // Saturating decrement towards strong-not-taken.
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign idx_f = pcf_i[IDX+1:2];
  assign tag_f = pcf_i[31:IDX+2];
  assign idx_e = pce_i[IDX+1:2];
  assign tag_e = pce_i[31:IDX+2];

  // Byte offset within the instruction word never selects an entry.
  assign unused_bits = ^{pcf_i[1:0], pce_i[1:0]};

  // The execute-stage branch already owns an entry if the tag matches.
  assign hit_e = valid[idx_e] && (etiqueta[idx_e] == tag_e);

  // Fetch lookup: pre-update contents, everything forced to zero on a miss.
  always_comb begin
    hitF_o        = 1'b0;
    prediccionF_o = 2'b00;
    selbpF_o      = 1'b0;
    destinoF_o    = 32'h0000_0000;
    if (!reset_i && valid[idx_f] && (etiqueta[idx_f] == tag_f)) begin
      hitF_o        = 1'b1;
      prediccionF_o = contador[idx_f];
      selbpF_o      = contador[idx_f][1];
      destinoF_o    = destino[idx_f];
    end else begin
      hitF_o        = 1'b0;
      prediccionF_o = 2'b00;
      selbpF_o      = 1'b0;
      destinoF_o    = 32'h0000_0000;
    end
  end

  // Valid bits and counters: async clear, train on hits, allocate on taken misses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid    <= '0;
      contador <= {ENTRADAS{2'b01}};
    end else if (actualiza_i) begin
      if (hit_e) begin
        if (tomado_i) begin
          contador[idx_e] <= sat_inc(contador[idx_e]);
        end else begin
          contador[idx_e] <= sat_dec(contador[idx_e]);
        end
      end else if (tomado_i) begin
        valid[idx_e]    <= 1'b1;
        contador[idx_e] <= 2'b10;
      end
    end
  end

  // Tag and target are written by every taken update; a hit rewrites the same tag.
  always_ff @(posedge clk_i) begin
    if (actualiza_i && tomado_i && !reset_i) begin
      etiqueta[idx_e] <= tag_e;
      destino[idx_e]  <= destinoe_i;
    end
  end

endmodule

// File: tb/tb_predictor_saltos.sv
// Self-checking bench for predictor_saltos: directed scenarios plus
// randomized traffic compared against an associative-style reference model.
module tb_predictor_saltos;

  localparam int N = 16;

  logic        clk;
  logic        reset;
  logic [31:0] pcf;
  logic        actualiza;
  logic [31:0] pce;
  logic        tomado;
  logic [31:0] destinoe;
  logic        hit;
  logic [1:0]  pred;
  logic        selbp;
  logic [31:0] destinof;

  int checks;
  int errors;

  predictor_saltos #(.ENTRADAS(N)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .pcf_i         (pcf),
    .actualiza_i   (actualiza),
    .pce_i         (pce),
    .tomado_i      (tomado),
    .destinoe_i    (destinoe),
    .hitF_o        (hit),
    .prediccionF_o (pred),
    .selbpF_o      (selbp),
    .destinoF_o    (destinof)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each slot remembers the full word address of its branch.
  logic        m_valid [N];
  logic [29:0] m_pcw   [N];
  int          m_ctr   [N];
  logic [31:0] m_dst   [N];

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    return !reset && m_valid[m_index(pc)] && (m_pcw[m_index(pc)] == pc[31:2]);
  endfunction

  function automatic logic [1:0] m_pred(input logic [31:0] pc);
    return m_hit(pc) ? 2'(m_ctr[m_index(pc)]) : 2'b00;
  endfunction

  function automatic logic m_sel(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_dest(input logic [31:0] pc);
    return m_hit(pc) ? m_dst[m_index(pc)] : 32'h0;
  endfunction

  // Model state update, following the branch-resolution rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] <= 1'b0;
        m_ctr[k]   <= 1;
      end
    end else if (actualiza) begin
      if (m_valid[m_index(pce)] && (m_pcw[m_index(pce)] == pce[31:2])) begin
        if (tomado) begin
          m_ctr[m_index(pce)] <= (m_ctr[m_index(pce)] >= 3) ? 3 : m_ctr[m_index(pce)] + 1;
          m_dst[m_index(pce)] <= destinoe;
        end else begin
          m_ctr[m_index(pce)] <= (m_ctr[m_index(pce)] <= 0) ? 0 : m_ctr[m_index(pce)] - 1;
        end
      end else if (tomado) begin
        m_valid[m_index(pce)] <= 1'b1;
        m_pcw[m_index(pce)]   <= pce[31:2];
        m_ctr[m_index(pce)]   <= 2;
        m_dst[m_index(pce)]   <= destinoe;
      end
    end
  end

  // Apply one cycle of inputs at the falling edge; outputs settle 1 ns later.
  task automatic drive(input logic [31:0] f, input logic act, input logic [31:0] e,
                       input logic tom, input logic [31:0] dst);
    @(negedge clk);
    pcf       = f;
    actualiza = act;
    pce       = e;
    tomado    = tom;
    destinoe  = dst;
    #1;
  endtask

  task automatic test_reset;
    pcf = 32'h100; actualiza = 1'b0; pce = 32'h0; tomado = 1'b0; destinoe = 32'h0;
    reset = 1'b0;
    #1 reset = 1'b1;
    // Taken update presented while reset is held must be ignored.
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h0000_0AAA);
    checks++;
    if (hit !== 1'b0 || pred !== 2'b00 || selbp !== 1'b0 || destinof !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got hit=%0b pred=%b sel=%0b dest=%h want 0 00 0 0", hit, pred, selbp, destinof);
    end
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h0000_0AAA);
    @(negedge clk);
    actualiza = 1'b0;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_cold;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL cold_hit got %0b want 0", hit); end
    checks++;
    if (pred !== 2'b00) begin errors++; $display("FAIL cold_pred got %b want 00", pred); end
    checks++;
    if (selbp !== 1'b0) begin errors++; $display("FAIL cold_sel got %0b want 0", selbp); end
    checks++;
    if (destinof !== 32'h0) begin errors++; $display("FAIL cold_dest got %h want 0", destinof); end
  endtask

  task automatic test_allocate;
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL alloc_preupdate_hit got %0b want 0", hit); end
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b1 || pred !== 2'b10 || selbp !== 1'b1 || destinof !== 32'h200) begin
      errors++;
      $display("FAIL alloc_lookup got hit=%0b pred=%b sel=%0b dest=%h want 1 10 1 200", hit, pred, selbp, destinof);
    end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 3; k++) drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (pred !== 2'b11) begin errors++; $display("FAIL sat_up got %b want 11", pred); end
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (pred !== 2'b11) begin errors++; $display("FAIL sat_hold_11 got %b want 11", pred); end
    for (int k = 0; k < 3; k++) drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b1 || pred !== 2'b00 || selbp !== 1'b0 || destinof !== 32'h200) begin
      errors++;
      $display("FAIL sat_down got hit=%0b pred=%b sel=%0b dest=%h want 1 00 0 200", hit, pred, selbp, destinof);
    end
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (pred !== 2'b00 || hit !== 1'b1) begin errors++; $display("FAIL sat_hold_00 got pred=%b hit=%0b want 00 1", pred, hit); end
  endtask

  task automatic test_same_cycle;
    // Counter is 00 here; lookup during a taken update still shows 00.
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
    checks++;
    if (hit !== 1'b1 || pred !== 2'b00) begin errors++; $display("FAIL same_cycle_old got hit=%0b pred=%b want 1 00", hit, pred); end
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h204);
    checks++;
    if (pred !== 2'b01 || selbp !== 1'b0 || destinof !== 32'h200) begin
      errors++;
      $display("FAIL same_cycle_next got pred=%b sel=%0b dest=%h want 01 0 200", pred, selbp, destinof);
    end
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (pred !== 2'b10 || selbp !== 1'b1 || destinof !== 32'h204) begin
      errors++;
      $display("FAIL same_cycle_after got pred=%b sel=%0b dest=%h want 10 1 204", pred, selbp, destinof);
    end
  endtask

  task automatic test_alias;
    drive(32'h100, 1'b1, 32'h140, 1'b1, 32'h444);
    drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b1 || pred !== 2'b10 || destinof !== 32'h444) begin
      errors++;
      $display("FAIL alias_new got hit=%0b pred=%b dest=%h want 1 10 444", hit, pred, destinof);
    end
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b0 || pred !== 2'b00 || destinof !== 32'h0) begin
      errors++;
      $display("FAIL alias_old got hit=%0b pred=%b dest=%h want 0 00 0", hit, pred, destinof);
    end
  endtask

  task automatic test_not_taken_miss;
    drive(32'h300, 1'b1, 32'h300, 1'b0, 32'h777);
    drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b0 || destinof !== 32'h0) begin errors++; $display("FAIL nt_miss got hit=%0b dest=%h want 0 0", hit, destinof); end
    drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b1 || pred !== 2'b10 || destinof !== 32'h444) begin
      errors++;
      $display("FAIL nt_miss_occupant got hit=%0b pred=%b dest=%h want 1 10 444", hit, pred, destinof);
    end
  endtask

  task automatic test_back_to_back;
    logic        tk   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ds   [5] = '{32'hA00, 32'hB00, 32'h0, 32'h0, 32'hC00};
    logic        eh   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  ep   [6] = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10};
    logic [31:0] ed   [6] = '{32'h0, 32'hA00, 32'hB00, 32'hB00, 32'hB00, 32'hC00};
    for (int k = 0; k < 6; k++) begin
      if (k < 5) drive(32'h204, 1'b1, 32'h204, tk[k], ds[k]);
      else       drive(32'h204, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (hit !== eh[k] || pred !== ep[k] || destinof !== ed[k]) begin
        errors++;
        $display("FAIL b2b_step%0d got hit=%0b pred=%b dest=%h want %0b %b %h", k, hit, pred, destinof, eh[k], ep[k], ed[k]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] f, e;
    for (int k = 0; k < 400; k++) begin
      e = 32'h1000 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      f = ($urandom_range(0, 1) == 0) ? e
          : 32'h1000 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      drive(f, 1'($urandom_range(0, 1)), e, 1'($urandom_range(0, 9) < 6), $urandom);
      checks++;
      if (hit !== m_hit(f) || pred !== m_pred(f) || selbp !== m_sel(f) || destinof !== m_dest(f)) begin
        errors++;
        $display("FAIL random_%0d pc=%h got hit=%0b pred=%b sel=%0b dest=%h want %0b %b %0b %h",
                 k, f, hit, pred, selbp, destinof, m_hit(f), m_pred(f), m_sel(f), m_dest(f));
      end
    end
  endtask

  task automatic test_async_reset;
    drive(32'h140, 1'b1, 32'h140, 1'b1, 32'h444);
    drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL areset_before got hit=%0b want 1", hit); end
    // Assert reset mid-cycle, well before the next rising edge.
    #1 reset = 1'b1;
    #1;
    checks++;
    if (hit !== 1'b0 || pred !== 2'b00 || selbp !== 1'b0 || destinof !== 32'h0) begin
      errors++;
      $display("FAIL areset_immediate got hit=%0b pred=%b sel=%0b dest=%h want 0 00 0 0", hit, pred, selbp, destinof);
    end
    actualiza = 1'b1; pce = 32'h140; tomado = 1'b1; destinoe = 32'h999;
    @(negedge clk);
    reset = 1'b0;
    actualiza = 1'b0;
    #1;
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL areset_release got hit=%0b want 0", hit); end
    drive(32'h140, 1'b1, 32'h140, 1'b1, 32'h888);
    drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (hit !== 1'b1 || pred !== 2'b10 || destinof !== 32'h888) begin
      errors++;
      $display("FAIL areset_realloc got hit=%0b pred=%b dest=%h want 1 10 888", hit, pred, destinof);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cold();
    test_allocate();
    test_saturation();
    test_same_cycle();
    test_alias();
    test_not_taken_miss();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
